// File: rtl/mem_arbiter_rr_if.sv
// Bundle of client-side and downstream memory signals around mem_arbiter_rr.
// master = arbiter view, slave = environment view (clients plus memory bridge).
interface mem_arbiter_rr_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 48,
  parameter int LEN_W       = 32,
  parameter int DATA_W      = 64
);
  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        rw;
  logic [NUM_CLIENTS*ADDR_W-1:0] addr;
  logic [NUM_CLIENTS*LEN_W-1:0]  len;
  logic [NUM_CLIENTS*DATA_W-1:0] wdata;
  logic [NUM_CLIENTS-1:0]        wready;
  logic [DATA_W-1:0]             rdata;
  logic [NUM_CLIENTS-1:0]        rvalid;
  logic [NUM_CLIENTS-1:0]        gnt;
  logic [NUM_CLIENTS-1:0]        ack;

  // Handshakes: a command or write beat transfers on a cycle where valid and
  // ready are both high; valid never waits on ready. Read beats have no ready:
  // m_rvalid/rvalid mean the beat is taken that cycle.
  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wvalid;
  logic              m_wready;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;

  modport master (
    input  req, rw, addr, len, wdata, m_cmd_ready, m_wready, m_rdata, m_rvalid,
    output wready, rdata, rvalid, gnt, ack,
           m_cmd_valid, m_rw, m_addr, m_len, m_wdata, m_wvalid
  );

  modport slave (
    output req, rw, addr, len, wdata, m_cmd_ready, m_wready, m_rdata, m_rvalid,
    input  wready, rdata, rvalid, gnt, ack,
           m_cmd_valid, m_rw, m_addr, m_len, m_wdata, m_wvalid
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter serialising client bursts onto one downstream burst port.
// Define MEM_ARB_PRIO0_EN to give client 0 strict priority over the others.
module mem_arbiter_rr #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 48,
  parameter int LEN_W       = 32,
  parameter int DATA_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_rr_if.master      bus,
  output logic [1:0]            state_dbg
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
`ifdef MEM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, g_q;
  logic [IDX_W-1:0]       win_idx, arb_cand;
  logic                   win_found;
  logic                   win_rw;
  logic [ADDR_W-1:0]      win_addr;
  logic [LEN_W-1:0]       win_len;
  logic [NUM_CLIENTS-1:0] win_oh;
  logic                   rw_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic [NUM_CLIENTS-1:0] gnt_q, ack_q;
  logic                   cmd_valid_q;
  logic [DATA_W-1:0]      sel_wdata, wdata_c, rdata_c;
  logic [NUM_CLIENTS-1:0] wready_c, rvalid_c;
  logic                   wvalid_c, beat_ok, last_beat;

  // Search upward from last+1; client 0 is pulled out of the rotation and
  // checked first when strict priority is enabled.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_cand  = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      arb_cand = IDX_W'((int'(last_q) + off) % NUM_CLIENTS);
      if (!win_found && bus.req[arb_cand] && !(PRIO0 && arb_cand == '0)) begin
        win_found = 1'b1;
        win_idx   = arb_cand;
      end
    end
    if (PRIO0 && bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
  end

  always_comb begin
    win_rw    = 1'b0;
    win_addr  = '0;
    win_len   = '0;
    win_oh    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_rw    = bus.rw[i];
        win_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        win_len   = bus.len[i*LEN_W +: LEN_W];
        win_oh[i] = 1'b1;
      end
      if (g_q == IDX_W'(i)) sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
    end
  end

  assign beat_ok   = (state_q == S_DATA) && (rw_q ? bus.m_wready : bus.m_rvalid);
  assign last_beat = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    wready_c = '0;
    rvalid_c = '0;
    wvalid_c = 1'b0;
    wdata_c  = '0;
    rdata_c  = '0;
    if (state_q == S_DATA) begin
      if (rw_q) begin
        wvalid_c = 1'b1;
        wdata_c  = sel_wdata;
      end else begin
        rdata_c  = bus.m_rdata;
      end
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (g_q == IDX_W'(i)) begin
          wready_c[i] = rw_q & bus.m_wready;
          rvalid_c[i] = ~rw_q & bus.m_rvalid;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_found) state_d = S_CMD;
      S_CMD:  if (cmd_valid_q && bus.m_cmd_ready) state_d = (len_q == '0) ? S_DONE : S_DATA;
      S_DATA: if (beat_ok && last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= IDX_W'(NUM_CLIENTS - 1);
      g_q         <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            g_q         <= win_idx;
            rw_q        <= win_rw;
            addr_q      <= win_addr;
            len_q       <= win_len;
            gnt_q       <= win_oh;
            cmd_valid_q <= 1'b1;
          end
        end
        S_CMD: begin
          cnt_q <= '0;
          if (bus.m_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            if (len_q == '0) ack_q <= gnt_q;
          end
        end
        S_DATA: begin
          if (beat_ok) begin
            if (last_beat) ack_q <= gnt_q;
            else           cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        S_DONE: begin
          gnt_q <= '0;
          // Under strict priority client 0 never moves the rotation pointer.
          if (!(PRIO0 && g_q == '0)) last_q <= g_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.ack         = ack_q;
  assign bus.m_cmd_valid = cmd_valid_q;
  assign bus.m_rw        = rw_q;
  assign bus.m_addr      = addr_q;
  assign bus.m_len       = len_q;
  assign bus.m_wvalid    = wvalid_c;
  assign bus.m_wdata     = wdata_c;
  assign bus.wready      = wready_c;
  assign bus.rvalid      = rvalid_c;
  assign bus.rdata       = rdata_c;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: transaction-level model checked every cycle, plus
// directed bursts with hand-computed timing and grant order.
module tb_mem_arbiter_rr;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int LW = 32;
  localparam int DW = 64;
`ifdef MEM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  localparam int P_ARB = 0, P_CMD = 1, P_XFER = 2, P_ACK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  mem_arbiter_rr_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) bus_if ();

  mem_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            md_phase, md_own, md_last, md_left, md_w;
  logic          md_rw;
  logic [AW-1:0] md_addr;
  logic [LW-1:0] md_len;

  // Winner = requester with the smallest rotation distance past 'lst'.
  function automatic int pick(input logic [N-1:0] r, input int lst);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    if (PRIO0 && r[0]) return 0;
    for (int i = 0; i < N; i++) begin
      if (PRIO0 && i == 0) continue;
      d = (i - lst - 1 + 2 * N) % N;
      if (r[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_phase = P_ARB;
      md_own   = -1;
      md_last  = N - 1;
      md_left  = 0;
      md_rw    = 1'b0;
      md_addr  = '0;
      md_len   = '0;
    end else begin
      case (md_phase)
        P_ARB: begin
          md_w = pick(bus_if.req, md_last);
          if (md_w >= 0) begin
            md_own   = md_w;
            md_rw    = bus_if.rw[md_w];
            md_addr  = bus_if.addr[md_w*AW +: AW];
            md_len   = bus_if.len[md_w*LW +: LW];
            md_phase = P_CMD;
          end
        end
        P_CMD: if (bus_if.m_cmd_ready) begin
          if (md_len == 0) md_phase = P_ACK;
          else begin
            md_left  = int'(md_len);
            md_phase = P_XFER;
          end
        end
        P_XFER: if (md_rw ? bus_if.m_wready : bus_if.m_rvalid) begin
          md_left--;
          if (md_left == 0) md_phase = P_ACK;
        end
        default: begin
          if (!(PRIO0 && md_own == 0)) md_last = md_own;
          md_own   = -1;
          md_phase = P_ARB;
        end
      endcase
    end
  end

  logic [N-1:0] e_oh, e_wr, e_rv;
  always @(negedge clk) begin
    if (!rst) begin
      e_oh = '0;
      if (md_own >= 0) e_oh[md_own] = 1'b1;
      e_wr = (md_phase == P_XFER && md_rw && bus_if.m_wready) ? e_oh : '0;
      e_rv = (md_phase == P_XFER && !md_rw && bus_if.m_rvalid) ? e_oh : '0;
      check("gnt", bus_if.gnt, e_oh);
      check("ack", bus_if.ack, (md_phase == P_ACK) ? e_oh : '0);
      check("m_cmd_valid", bus_if.m_cmd_valid, md_phase == P_CMD);
      check("m_rw", bus_if.m_rw, md_rw);
      check("m_addr", bus_if.m_addr, md_addr);
      check("m_len", bus_if.m_len, md_len);
      check("m_wvalid", bus_if.m_wvalid, md_phase == P_XFER && md_rw);
      check("wready", bus_if.wready, e_wr);
      check("rvalid", bus_if.rvalid, e_rv);
      if (md_phase == P_XFER && md_rw) check("m_wdata", bus_if.m_wdata, bus_if.wdata[md_own*DW +: DW]);
      if (e_rv != '0) check("rdata", bus_if.rdata, bus_if.m_rdata);
    end
  end

  // ---------------- scoreboard: completion order ----------------
  always @(negedge clk) begin
    if (!rst && bus_if.ack != '0) begin
      if (exp_q.size() == 0) check("ack_unexpected", bus_if.ack, '0);
      else check("ack_order", bus_if.ack, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0]   cr_pat, wr_pat, rv_pat;
  logic [DW-1:0] rd_pat [32];
  logic [DW-1:0] rd_got [$];
  int            cmd_cyc, hs_cyc, beats, ack_cyc, n_ack;
  logic [N-1:0]  rv_or, wr_or, gnt_c1;
  logic [AW-1:0] addr_c1;
  logic [LW-1:0] len_c1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_client(input int c, input logic r, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input logic [DW-1:0] d);
    bus_if.rw[c]              = r;
    bus_if.addr[c*AW +: AW]   = a;
    bus_if.len[c*LW +: LW]    = l;
    bus_if.wdata[c*DW +: DW]  = d;
  endtask

  // Cycle 0 is the IDLE cycle in which req is first presented.
  task automatic watch(input int c, input int ncyc, input int drop_at);
    cmd_cyc = -1; hs_cyc = -1; beats = 0; ack_cyc = -1;
    rv_or = '0; wr_or = '0; gnt_c1 = '0; addr_c1 = '0; len_c1 = '1;
    rd_got.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      bus_if.m_cmd_ready = cr_pat[cyc];
      bus_if.m_wready    = wr_pat[cyc];
      bus_if.m_rvalid    = rv_pat[cyc];
      bus_if.m_rdata     = rd_pat[cyc];
      @(negedge clk);
      if (cyc == 1) begin
        gnt_c1  = bus_if.gnt;
        addr_c1 = bus_if.m_addr;
        len_c1  = bus_if.m_len;
      end
      if (bus_if.m_cmd_valid && cmd_cyc < 0) cmd_cyc = cyc;
      if (bus_if.m_cmd_valid && bus_if.m_cmd_ready && hs_cyc < 0) hs_cyc = cyc;
      if (bus_if.wready[c] || bus_if.rvalid[c]) beats++;
      if (bus_if.rvalid[c]) rd_got.push_back(bus_if.rdata);
      rv_or = rv_or | bus_if.rvalid;
      wr_or = wr_or | bus_if.wready;
      if (bus_if.ack[c] && ack_cyc < 0) ack_cyc = cyc;
      tick();
      if (cyc == drop_at) bus_if.req = '0;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus_if.req = '0; bus_if.rw = '0; bus_if.addr = '0; bus_if.len = '0; bus_if.wdata = '0;
    bus_if.m_cmd_ready = 1'b1; bus_if.m_wready = 1'b1;
    bus_if.m_rdata = '0; bus_if.m_rvalid = 1'b0;
    for (int i = 0; i < 32; i++) rd_pat[i] = 64'h5555;
    cr_pat = '1; wr_pat = '1; rv_pat = '0;

    #1;
    check("rst_gnt", bus_if.gnt, 4'b0000);
    check("rst_ack", bus_if.ack, 4'b0000);
    check("rst_cmd_valid", bus_if.m_cmd_valid, 1'b0);
    check("rst_m_addr", bus_if.m_addr, 48'h0);
    check("rst_m_len", bus_if.m_len, 32'h0);
    check("rst_state", state_dbg, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single write burst from client 2
    set_client(2, 1'b1, 48'h1000, 32'd4, 64'h2222_0000_0000_2222);
    bus_if.req = 4'b0100;
    exp_q.push_back(4'b0100);
    watch(2, 12, 1);
    check("single_gnt_c1", gnt_c1, 4'b0100);
    check("single_addr_c1", addr_c1, 48'h1000);
    check("single_len_c1", len_c1, 32'd4);
    check("single_cmd_cycle", cmd_cyc, 1);
    check("single_beats", beats, 4);
    check("single_ack_cycle", ack_cyc, 6);

    // fairness: all four clients, len=1 writes
    do_reset();
    for (int c = 0; c < N; c++) set_client(c, 1'b1, 48'h100 * c, 32'd1, 64'hF000 + c);
    bus_if.m_cmd_ready = 1'b1;
    bus_if.m_wready    = 1'b1;
    bus_if.req         = 4'b1111;
    if (PRIO0) begin
      for (int k = 0; k < 5; k++) exp_q.push_back(4'b0001);
    end else begin
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    end
    n_ack = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus_if.ack != '0) n_ack++;
      tick();
      if (n_ack == 5) break;
    end
    bus_if.req = '0;
    check("fair_ack_count", n_ack, 5);
    repeat (3) tick();

    // zero-length read from client 1, command stalled two cycles
    set_client(1, 1'b0, 48'h2000, 32'd0, 64'h1111);
    bus_if.req = 4'b0010;
    cr_pat = 32'hFFFF_FFF8; wr_pat = '1; rv_pat = '1;
    exp_q.push_back(4'b0010);
    watch(1, 8, 1);
    check("zero_len_c1", len_c1, 32'd0);
    check("zero_hs_cycle", hs_cyc, 3);
    check("zero_ack_cycle", ack_cyc, 4);
    check("zero_beats", beats, 0);
    check("zero_wready_seen", wr_or, 4'b0000);
    check("zero_rvalid_seen", rv_or, 4'b0000);

    // read routing to client 3
    set_client(3, 1'b0, 48'h4000, 32'd2, 64'h3333);
    bus_if.req = 4'b1000;
    cr_pat = '1; wr_pat = '1; rv_pat = 32'h14;
    rd_pat[2] = 64'hAAAA; rd_pat[4] = 64'hBBBB;
    exp_q.push_back(4'b1000);
    watch(3, 10, 1);
    check("read_beats", beats, 2);
    check("read_ack_cycle", ack_cyc, 5);
    check("read_rvalid_seen", rv_or, 4'b1000);
    check("read_count", rd_got.size(), 2);
    if (rd_got.size() == 2) begin
      check("read_data0", rd_got[0], 64'hAAAA);
      check("read_data1", rd_got[1], 64'hBBBB);
    end
    rd_pat[2] = 64'h5555; rd_pat[4] = 64'h5555;

    // write backpressure from client 0
    set_client(0, 1'b1, 48'h3000, 32'd3, 64'h0A0A_0B0B);
    bus_if.req = 4'b0001;
    cr_pat = '1; wr_pat = 32'h64; rv_pat = '0;
    exp_q.push_back(4'b0001);
    watch(0, 12, 1);
    check("bp_hs_cycle", hs_cyc, 1);
    check("bp_beats", beats, 3);
    check("bp_ack_cycle", ack_cyc, 7);

    // reset in the middle of a 4-beat write from client 1
    set_client(1, 1'b1, 48'h5000, 32'd4, 64'h5A5A);
    bus_if.req = 4'b0010;
    bus_if.m_cmd_ready = 1'b1;
    bus_if.m_wready    = 1'b1;
    beats = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus_if.wready[1]) beats++;
      tick();
      if (cyc == 1) bus_if.req = '0;
      if (beats == 1) break;
    end
    check("midrst_beats_before", beats, 1);
    rst = 1'b1;
    #1;
    check("midrst_gnt", bus_if.gnt, 4'b0000);
    check("midrst_ack", bus_if.ack, 4'b0000);
    check("midrst_wready", bus_if.wready, 4'b0000);
    check("midrst_wvalid", bus_if.m_wvalid, 1'b0);
    check("midrst_cmd_valid", bus_if.m_cmd_valid, 1'b0);
    check("midrst_m_addr", bus_if.m_addr, 48'h0);
    check("midrst_state", state_dbg, 2'd0);
    bus_if.req = '0;
    tick();
    tick();
    rst = 1'b0;
    set_client(0, 1'b1, 48'h6000, 32'd1, 64'h6060);
    set_client(1, 1'b1, 48'h7000, 32'd1, 64'h7070);
    bus_if.req = 4'b0011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(PRIO0 ? 4'b0001 : 4'b0010);
    n_ack = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus_if.ack != '0) n_ack++;
      tick();
      if (n_ack == 2) break;
    end
    bus_if.req = '0;
    check("post_rst_ack_count", n_ack, 2);
    repeat (4) tick();

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
